// File: rtl/ca_live_cell_lister_pkg.sv
// Shared definitions for the CA live-cell lister and the neighbour-rule update stage.
// Grid geometry, cell index type, lister FSM encoding and an edge-cell helper.
package ca_pkg;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);

    typedef logic [IDX_W-1:0] cell_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } list_state_t;

    // True when the cell touches the torus-wrap boundary (first/last row or column)
    function automatic logic is_edge_cell(input cell_idx_t idx);
        int row;
        int col;
        row = int'(idx) / COLS;
        col = int'(idx) % COLS;
        return (row == 0) || (row == ROWS - 1) || (col == 0) || (col == COLS - 1);
    endfunction

endpackage

// File: rtl/ca_live_cell_lister_if.sv
// Output stream of the live-cell lister: one cell index per beat.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
// once out_valid is high it stays high with out_idx/out_last/out_edge stable
// until that transfer, and out_valid never depends on out_ready.
// Optional macro CA_LIST_EDGE_TAG_EN adds the out_edge tag.
interface ca_live_cell_lister_if;
    import ca_pkg::*;

    logic      out_valid;
    logic      out_ready;
    cell_idx_t out_idx;
    logic      out_last;
`ifdef CA_LIST_EDGE_TAG_EN
    logic      out_edge;

    modport master (output out_valid, output out_idx, output out_last, output out_edge,
                    input out_ready);
    modport slave  (input out_valid, input out_idx, input out_last, input out_edge,
                    output out_ready);
`else
    modport master (output out_valid, output out_idx, output out_last, input out_ready);
    modport slave  (input out_valid, input out_idx, input out_last, output out_ready);
`endif

endinterface

// File: rtl/ca_live_cell_lister_lsb_encoder.sv
// Purely combinational lowest-set-bit finder over the whole grid vector.
// idx is the position of the lowest 1; any flags a non-zero vector (idx=0 when empty).
module ca_lsb_encoder
    import ca_pkg::*;
(
    input  logic [CELLS-1:0] vec,
    output cell_idx_t        idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one to win
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = cell_idx_t'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ca_live_cell_lister.sv
// Live-cell lister: snapshots the CA grid on start and streams the index of
// every live cell in ascending order, one per accepted beat, then pulses done.
// Optional macro CA_LIST_EDGE_TAG_EN adds out_edge (cell on a wrap boundary).
module ca_live_cell_lister
    import ca_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CELLS-1:0]            grid_in,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W:0]              live_count,
    output list_state_t                 state_dbg,
    ca_live_cell_lister_if.master       out
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EMIT = EMIT;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [CELLS-1:0] ONE = {{(CELLS-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CELLS-1:0] snap;
    logic [CELLS-1:0] snap_rest;
    cell_idx_t        lsb_idx;
    logic             lsb_any;
    logic             emit_active;
    logic             beat_last;
    logic             fire;

    ca_lsb_encoder u_lsb (
        .vec (snap),
        .idx (lsb_idx),
        .any (lsb_any)
    );

    // snap with its lowest live cell cleared; empty remainder means this is the last beat
    assign snap_rest   = snap & (snap - ONE);
    assign emit_active = (state == S_EMIT) && lsb_any;
    assign beat_last   = (snap_rest == '0);
    assign fire        = emit_active && out.out_ready;

    assign out.out_valid = emit_active;
    assign out.out_idx   = emit_active ? lsb_idx : '0;
    assign out.out_last  = emit_active && beat_last;
`ifdef CA_LIST_EDGE_TAG_EN
    assign out.out_edge  = emit_active && is_edge_cell(lsb_idx);
`endif

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = list_state_t'(state);

    // Next-state: empty grid skips straight to DONE; last accepted beat ends the pass
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (grid_in != '0) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                if (fire && beat_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Snapshot register: loaded once per pass, peeled one live cell per accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap <= '0;
        end else if (state == S_IDLE && start) begin
            snap <= grid_in;
        end else if (fire) begin
            snap <= snap_rest;
        end
    end

    // Beat counter: cleared on an accepted start, holds after the pass until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_count <= '0;
        end else if (state == S_IDLE && start) begin
            live_count <= '0;
        end else if (fire) begin
            live_count <= live_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ca_live_cell_lister.sv
// Self-checking bench for ca_live_cell_lister.
// Expected beats {edge,last,idx} are queued when a pass starts and checked by
// a monitor on every handshake; scenario tasks check timing/control inline.
// Optional macro CA_LIST_EDGE_TAG_EN enables out_edge checking.
`timescale 1ns/1ps
module tb_ca_live_cell_lister;
    import ca_pkg::*;

    localparam int W = IDX_W + 2;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [CELLS-1:0]   grid_in;
    logic               busy;
    logic               done;
    logic [IDX_W:0]     live_count;
    list_state_t        state_dbg;

    ca_live_cell_lister_if bus ();

    ca_live_cell_lister dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .grid_in    (grid_in),
        .busy       (busy),
        .done       (done),
        .live_count (live_count),
        .state_dbg  (state_dbg),
        .out        (bus.master)
    );

    logic [W-1:0] exp_q[$];
    int vectors;
    int miscompares;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // independent model of the expected stream for a grid
    task automatic push_model(input logic [CELLS-1:0] g);
        int hi;
        int r;
        int c;
        logic e;
        hi = -1;
        for (int i = 0; i < CELLS; i++) if (g[i]) hi = i;
        for (int i = 0; i < CELLS; i++) begin
            if (g[i]) begin
                r = i / COLS;
                c = i - r * COLS;
`ifdef CA_LIST_EDGE_TAG_EN
                e = (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1);
`else
                e = 1'b0;
`endif
                exp_q.push_back({e, (i == hi), IDX_W'(i)});
            end
        end
    endtask

    // scoreboard monitor: a beat transfers at the next posedge when valid&ready
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (rst_n && bus.out_valid && bus.out_ready) begin
`ifdef CA_LIST_EDGE_TAG_EN
            got = {bus.out_edge, bus.out_last, bus.out_idx};
`else
            got = {1'b0, bus.out_last, bus.out_idx};
`endif
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected got=%h expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL beat {edge,last,idx} got=%h expected=%h", got, exp);
                end
            end
        end
    end

    task automatic begin_pass(input logic [CELLS-1:0] g);
        grid_in = g;
        start   = 1'b1;
        push_model(g);
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || live_count !== '0
            || bus.out_idx !== '0 || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset valid=%b busy=%b done=%b cnt=%0d idx=%0d last=%b expected all 0",
                     bus.out_valid, busy, done, live_count, bus.out_idx, bus.out_last);
        end
    endtask

    task automatic test_two_cells();
        bus.out_ready = 1'b1;
        begin_pass(CELLS'(1) | (CELLS'(1) << 63));
        // c1: first beat valid
        vectors++;
        if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL two_c1 valid=%b busy=%b expected 1 1", bus.out_valid, busy);
        end
        tick(); // c2: idx63 last
        tick(); // c3: done
        vectors++;
        if (done !== 1'b1 || bus.out_valid !== 1'b0 || live_count !== 7'd2) begin
            miscompares++;
            $display("FAIL two_done done=%b valid=%b cnt=%0d expected 1 0 2", done, bus.out_valid, live_count);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || live_count !== 7'd2) begin
            miscompares++;
            $display("FAIL two_after done=%b busy=%b cnt=%0d expected 0 0 2", done, busy, live_count);
        end
    endtask

    task automatic test_empty_grid();
        bus.out_ready = 1'b1;
        begin_pass('0);
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 || bus.out_valid !== 1'b0 || live_count !== '0) begin
            miscompares++;
            $display("FAIL empty_c1 done=%b busy=%b valid=%b cnt=%0d expected 1 1 0 0",
                     done, busy, bus.out_valid, live_count);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL empty_c2 done=%b busy=%b valid=%b expected 0 0 0", done, busy, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        begin_pass((CELLS'(1) << 9) | (CELLS'(1) << 18) | (CELLS'(1) << 27));
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 6'd9 || bus.out_last !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_c%0d valid=%b idx=%0d last=%b expected 1 9 0",
                         c, bus.out_valid, bus.out_idx, bus.out_last);
            end
            tick();
        end
        bus.out_ready = 1'b1; // c4..c6 beats 9,18,27
        tick();
        tick();
        vectors++;
        if (bus.out_idx !== 6'd27 || bus.out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_last idx=%0d last=%b expected 27 1", bus.out_idx, bus.out_last);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || live_count !== 7'd3) begin
            miscompares++;
            $display("FAIL bp_done done=%b cnt=%0d expected 1 3", done, live_count);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        logic [CELLS-1:0] g;
        int pop;
        bit seen;
        g = {$urandom(), $urandom()} | CELLS'(3);
        pop = $countones(g);
        bus.out_ready = 1'($urandom_range(0, 1));
        begin_pass(g);
        start   = 1'b1;  // ignored: not in IDLE
        grid_in = '0;    // must not affect the stream
        tick();
        start   = 1'b0;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) seen = 1;
        end
        vectors++;
        if (!seen || live_count !== 7'(pop) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ignore_start done_seen=%0d cnt=%0d left=%0d expected 1 %0d 0",
                     seen, live_count, exp_q.size(), pop);
        end
        tick();
    endtask

    task automatic test_reset_mid_pass();
        bus.out_ready = 1'b1;
        begin_pass('1);
        tick();
        tick(); // two beats accepted
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || live_count !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset valid=%b busy=%b cnt=%0d done=%b expected 0 0 0 0",
                     bus.out_valid, busy, live_count, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_grid();
        bit seen;
        bus.out_ready = 1'b1;
        begin_pass('1);
        vectors++;
        if (bus.out_idx !== '0 || bus.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_first idx=%0d valid=%b expected 0 1", bus.out_idx, bus.out_valid);
        end
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        vectors++;
        if (!seen || live_count !== 7'd64 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_done done_seen=%0d cnt=%0d left=%0d expected 1 64 0",
                     seen, live_count, exp_q.size());
        end
        tick();
        tick();
        vectors++;
        if (live_count !== 7'd64 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_hold cnt=%0d busy=%b expected 64 0", live_count, busy);
        end
    endtask

    task automatic test_random_passes();
        logic [CELLS-1:0] g;
        bit seen;
        for (int p = 0; p < 4; p++) begin
            g = {$urandom(), $urandom()} & {$urandom(), $urandom()};
            bus.out_ready = 1'b1;
            begin_pass(g);
            seen = done;
            for (int i = 0; i < 400 && !seen; i++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                tick();
                if (done) seen = 1;
            end
            vectors++;
            if (!seen || live_count !== 7'($countones(g)) || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL rand_pass%0d done_seen=%0d cnt=%0d left=%0d expected 1 %0d 0",
                         p, seen, live_count, exp_q.size(), $countones(g));
            end
            tick();
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        grid_in       = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_two_cells();
        test_empty_grid();
        test_backpressure();
        test_ignore_start();
        test_reset_mid_pass();
        test_full_grid();
        test_random_passes();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
